pc_fetch_gen: RTL and testbench

//  Parametrised fetch-PC generator for the yadan core. Successor to the single-step PC register:

---
 rtl/pc_fetch_gen.sv | 164 ++++++++++++++++
 tb/tb_pc_fetch_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_gen.sv
// Purpose : fetch-PC generator with prioritised trap/branch redirects and an imem valid/ready request.
// Latency : one cycle from redirect or acceptance to the new pc_o.
// Backpres: an unaccepted request holds pc_o/req_valid_o stable; redirects seen meanwhile are buffered.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   en_i, stall_i                 core running / pipeline stall (act only after a presented request is accepted)
//   trap_valid_i, trap_addr_i     trap redirect (highest priority)
//   branch_valid_i, branch_addr_i branch/jump redirect
//   req_ready_i, req_valid_o      imem request handshake; pc_o is the request address
//   ce_o                          fetch chip enable (any state but IDLE)
//   misalign_o, misalign_addr_o   pulse when a misaligned target was aligned down, plus the original target
module pc_fetch_gen #(
  parameter int unsigned        ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]  START_ADDR  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0]  END_ADDR    = 32'h0000_FFFC,
  parameter int unsigned        FETCH_BYTES = 4,
  parameter int unsigned        ALIGN_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              stall_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              branch_valid_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              req_ready_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(ALIGN_BYTES - 1);
  localparam logic [ADDR_W-1:0] FETCH_INC  = ADDR_W'(FETCH_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;

  // Redirect that arrived while the current request was still waiting for ready.
  logic              pend_vld;
  logic              pend_trap;
  logic [ADDR_W-1:0] pend_addr;

  logic              redir_vld;
  logic              redir_trap;
  logic [ADDR_W-1:0] redir_addr;
  logic              redir_misaligned;
  logic              blocked;
  logic              accepted;
  logic [ADDR_W-1:0] seq_pc;

  // Merge order: incoming trap, pending trap, incoming branch, pending branch.
  // A pending trap must beat a fresh branch, otherwise a branch resolving in
  // the shadow of a blocked trap would overwrite it.
  always_comb begin
    redir_vld  = 1'b1;
    redir_trap = 1'b0;
    redir_addr = '0;
    if (trap_valid_i) begin
      redir_trap = 1'b1;
      redir_addr = trap_addr_i;
    end else if (pend_vld && pend_trap) begin
      redir_trap = 1'b1;
      redir_addr = pend_addr;
    end else if (branch_valid_i) begin
      redir_addr = branch_addr_i;
    end else if (pend_vld) begin
      redir_addr = pend_addr;
    end else begin
      redir_vld = 1'b0;
    end
  end

  assign blocked          = (state == ISSUE) && !req_ready_i;
  assign accepted         = (state == ISSUE) && req_ready_i;
  assign redir_misaligned = |(redir_addr & ALIGN_MASK);
  // Wrap is a >= compare so a redirect that landed beyond the window
  // falls back to START_ADDR on its first sequential step.
  assign seq_pc           = (pc_o >= END_ADDR) ? START_ADDR : pc_o + FETCH_INC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      req_valid_o     <= 1'b0;
      ce_o            <= 1'b0;
      pc_o            <= START_ADDR;
      pend_vld        <= 1'b0;
      pend_trap       <= 1'b0;
      pend_addr       <= '0;
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      misalign_o <= 1'b0;

      // PC / pending-redirect update
      if (blocked) begin
        // Address must stay stable while presented; park the redirect.
        if (redir_vld) begin
          pend_vld  <= 1'b1;
          pend_trap <= redir_trap;
          pend_addr <= redir_addr;
        end
      end else if (redir_vld) begin
        pc_o     <= redir_addr & ~ALIGN_MASK;
        pend_vld <= 1'b0;
        if (redir_misaligned) begin
          misalign_o      <= 1'b1;
          misalign_addr_o <= redir_addr;
        end
      end else if (accepted) begin
        pc_o <= seq_pc;
      end

      // Request FSM; outputs registered alongside the state
      case (state)
        IDLE: begin
          if (en_i) begin
            state       <= stall_i ? HOLD : ISSUE;
            req_valid_o <= !stall_i;
            ce_o        <= 1'b1;
          end
        end
        ISSUE: begin
          if (req_ready_i) begin
            if (!en_i) begin
              state       <= IDLE;
              req_valid_o <= 1'b0;
              ce_o        <= 1'b0;
            end else if (stall_i) begin
              state       <= HOLD;
              req_valid_o <= 1'b0;
              ce_o        <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!en_i) begin
            state       <= IDLE;
            req_valid_o <= 1'b0;
            ce_o        <= 1'b0;
          end else if (!stall_i) begin
            state       <= ISSUE;
            req_valid_o <= 1'b1;
            ce_o        <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          req_valid_o <= 1'b0;
          ce_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Bench for pc_fetch_gen: directed vector table for the named corner cases,
// then randomized traffic checked against a transaction-level model.
// A second instance with an 8-byte step checks the wider-step wrap.
module tb_pc_fetch_gen;

  localparam logic [31:0] START = 32'h0000_0000;
  localparam logic [31:0] ENDA  = 32'h0000_FFFC;
  localparam int unsigned STEP  = 4;
  localparam int unsigned ALIGN = 4;

  logic        clk = 1'b0;
  logic        rst, en, stall, tv, bv, rdy;
  logic [31:0] ta, ba;
  logic        vld, ce, mis;
  logic [31:0] pc, maddr;
  logic        vld8, ce8, mis8;
  logic [31:0] pc8, maddr8;

  always #5 clk = ~clk;

  pc_fetch_gen dut (
    .clk(clk), .rst(rst), .en_i(en), .stall_i(stall),
    .trap_valid_i(tv), .trap_addr_i(ta), .branch_valid_i(bv), .branch_addr_i(ba),
    .req_ready_i(rdy), .req_valid_o(vld), .pc_o(pc), .ce_o(ce),
    .misalign_o(mis), .misalign_addr_o(maddr)
  );

  pc_fetch_gen #(.END_ADDR(32'h0000_FFF8), .FETCH_BYTES(8)) dut8 (
    .clk(clk), .rst(rst), .en_i(en), .stall_i(stall),
    .trap_valid_i(tv), .trap_addr_i(ta), .branch_valid_i(bv), .branch_addr_i(ba),
    .req_ready_i(rdy), .req_valid_o(vld8), .pc_o(pc8), .ce_o(ce8),
    .misalign_o(mis8), .misalign_addr_o(maddr8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        trap;
    logic [31:0] addr;
  } redir_t;

  redir_t      pend_q[$];
  logic        m_vld, m_ce, m_mis;
  logic [31:0] m_pc, m_maddr;

  // Computes what the outputs should be after the coming clock edge,
  // from the inputs currently applied.
  task automatic model_step();
    logic        have;
    logic        is_trap;
    logic [31:0] tgt;
    if (rst) begin
      m_pc = START; m_vld = 1'b0; m_ce = 1'b0; m_mis = 1'b0; m_maddr = '0;
      pend_q.delete();
      return;
    end
    have = 1'b1; is_trap = 1'b0; tgt = '0;
    if (tv) begin
      is_trap = 1'b1; tgt = ta;
    end else if (pend_q.size() != 0 && pend_q[0].trap) begin
      is_trap = 1'b1; tgt = pend_q[0].addr;
    end else if (bv) begin
      tgt = ba;
    end else if (pend_q.size() != 0) begin
      tgt = pend_q[0].addr;
    end else begin
      have = 1'b0;
    end
    m_mis = 1'b0;
    if (m_vld && !rdy) begin
      if (have) begin
        redir_t r;
        r.trap = is_trap;
        r.addr = tgt;
        pend_q.delete();
        pend_q.push_back(r);
      end
    end else begin
      if (have) begin
        pend_q.delete();
        m_pc = tgt - (tgt % ALIGN);
        if (tgt % ALIGN != 0) begin
          m_mis   = 1'b1;
          m_maddr = tgt;
        end
      end else if (m_vld) begin
        m_pc = (m_pc >= ENDA) ? START : m_pc + STEP;
      end
      // Request is free to change: running/stalled decide the next one.
      if (!en) begin
        m_vld = 1'b0; m_ce = 1'b0;
      end else begin
        m_ce = 1'b1; m_vld = !stall;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r, e, s, tv;
    logic [31:0] ta;
    logic        bv;
    logic [31:0] ba;
    logic        rdy;
    logic [31:0] pc;
    logic        vld, ce, mis;
    logic [31:0] maddr;
    logic        c8;
    logic [31:0] pc8;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic e, input logic s,
    input logic t_v, input logic [31:0] t_a,
    input logic b_v, input logic [31:0] b_a, input logic ry,
    input logic [31:0] p, input logic v, input logic c, input logic m,
    input logic [31:0] ma, input logic c8, input logic [31:0] p8);
    vec_t x;
    x.r = r; x.e = e; x.s = s; x.tv = t_v; x.ta = t_a; x.bv = b_v; x.ba = b_a;
    x.rdy = ry; x.pc = p; x.vld = v; x.ce = c; x.mis = m; x.maddr = ma;
    x.c8 = c8; x.pc8 = p8;
    return x;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return {16'h0, 16'($urandom_range(0, 16383) * 4)};
      2:       return 32'h0000_FFF0 + 32'($urandom_range(0, 15));
      default: return 32'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; stall = 1'b0; tv = 1'b0; bv = 1'b0; rdy = 1'b1;
    ta = '0; ba = '0;
    m_pc = START; m_vld = 1'b0; m_ce = 1'b0; m_mis = 1'b0; m_maddr = '0;

    //                  r  e  s  tv ta             bv ba             rdy  pc             vld ce mis maddr         c8 pc8
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h0,        0, 0, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h0,        0, 0, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h0,        1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h4,        1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h8,        1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'hC,        1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h10,       1, 1, 0, 32'h0,   0, 32'h0));
    // blocked branch is buffered, applied one cycle after acceptance
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h200,      0,   32'h10,       1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0,   32'h10,       1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0,   32'h10,       1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h200,      1, 1, 0, 32'h0,   0, 32'h0));
    // trap beats branch; pending trap beats a later incoming branch
    vecs.push_back(mk(0, 1, 0, 1, 32'h80,       1, 32'h300,      1,   32'h80,       1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h84,       1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h80,       0, 32'h0,        0,   32'h84,       1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h300,      0,   32'h84,       1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h80,       1, 1, 0, 32'h0,   0, 32'h0));
    // stall after acceptance, redirect taken in HOLD
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        1,   32'h84,       0, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h44,       1,   32'h44,       0, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        1,   32'h44,       0, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h44,       1, 1, 0, 32'h0,   0, 32'h0));
    // misaligned branch, then reset over an unaccepted request
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h102,      1,   32'h100,      1, 1, 1, 32'h102, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0,   32'h100,      1, 1, 0, 32'h102, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0,   32'h0,        0, 0, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h0,        1, 1, 0, 32'h0,   0, 32'h0));
    // wrap at end of window, both step sizes
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'hFFF8,     1,   32'hFFF8,     1, 1, 0, 32'h0,   1, 32'hFFF8));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'hFFFC,     1, 1, 0, 32'h0,   1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h0,        1, 1, 0, 32'h0,   1, 32'h8));
    // disable after acceptance, redirect taken while IDLE
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   32'h4,        0, 0, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h20,       1,   32'h20,       0, 0, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h20,       1, 1, 0, 32'h0,   0, 32'h0));
    // target outside the window taken as-is, next step wraps
    vecs.push_back(mk(0, 1, 0, 1, 32'h2_0000,   0, 32'h0,        1,   32'h2_0000,   1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h0,        1, 1, 0, 32'h0,   0, 32'h0));
    // misaligned trap parked while blocked, flagged when applied
    vecs.push_back(mk(0, 1, 0, 1, 32'h13,       0, 32'h0,        0,   32'h0,        1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   32'h10,       1, 1, 1, 32'h13,  0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; en = vecs[i].e; stall = vecs[i].s;
      tv = vecs[i].tv; ta = vecs[i].ta; bv = vecs[i].bv; ba = vecs[i].ba;
      rdy = vecs[i].rdy;
      cycle();
      chk($sformatf("row%0d pc", i),    pc,            vecs[i].pc);
      chk($sformatf("row%0d vld", i),   32'(vld),      32'(vecs[i].vld));
      chk($sformatf("row%0d ce", i),    32'(ce),       32'(vecs[i].ce));
      chk($sformatf("row%0d mis", i),   32'(mis),      32'(vecs[i].mis));
      chk($sformatf("row%0d maddr", i), maddr,         vecs[i].maddr);
      if (vecs[i].c8) chk($sformatf("row%0d pc8", i), pc8, vecs[i].pc8);
    end

    // ---------------- randomized traffic vs model ----------------
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 3) == 0);
      tv    = ($urandom_range(0, 15) == 0);
      bv    = ($urandom_range(0, 5) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      ta    = rand_addr();
      ba    = rand_addr();
      cycle();
      chk($sformatf("rnd%0d pc", n),    pc,       m_pc);
      chk($sformatf("rnd%0d vld", n),   32'(vld), 32'(m_vld));
      chk($sformatf("rnd%0d ce", n),    32'(ce),  32'(m_ce));
      chk($sformatf("rnd%0d mis", n),   32'(mis), 32'(m_mis));
      chk($sformatf("rnd%0d maddr", n), maddr,    m_maddr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
